// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array sequencer.
package sa_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned PSUM_W   = 24;
    localparam int unsigned DEF_ROWS = 4;
    localparam int unsigned DEF_COLS = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StFeed,
        StDrain,
        StDone
    } sa_state_e;

endpackage

// File: rtl/sa_valid_delay.sv
// DEPTH-stage 1-bit valid shift register with async reset and synchronous flush.
module sa_valid_delay #(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [DEPTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = '0;
        if (!flush_i) begin
            sr_d = {sr_q[DEPTH-2:0], valid_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign valid_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sa_ctrl.sv
// Job sequencer for the weight-stationary systolic array: weight load, activation feed and
// result tracking through a latency-matched valid delay line.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned MAX_VECS = 255,
    parameter int unsigned RES_LAT  = ROWS + COLS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_VECS+1)-1:0] cfg_num_vecs,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic                          wgt_rd_en,
    output logic [$clog2(ROWS)-1:0]       wgt_rd_addr,
    output logic                          arr_load_weight,
    output logic                          act_rd_en,
    output logic [$clog2(MAX_VECS)-1:0]   act_rd_addr,
    output logic                          arr_act_valid,
    output logic                          res_valid,
    output logic [$clog2(MAX_VECS)-1:0]   res_idx
);

    localparam int unsigned WA_W = $clog2(ROWS);
    localparam int unsigned VA_W = $clog2(MAX_VECS);
    localparam int unsigned NV_W = $clog2(MAX_VECS + 1);

    sa_state_e       state_q, state_d;
    logic [NV_W-1:0] num_vecs_q, num_vecs_d;
    logic            wgt_rd_en_q, wgt_rd_en_d;
    logic [WA_W-1:0] wgt_addr_q, wgt_addr_d;
    logic            load_w_q, load_w_d;
    logic            act_rd_en_q, act_rd_en_d;
    logic [VA_W-1:0] act_addr_q, act_addr_d;
    logic            act_valid_q, act_valid_d;
    logic [VA_W-1:0] res_idx_q, res_idx_d;
    logic            done_q, done_d;
    logic            cfg_err_q, cfg_err_d;
    logic [VA_W-1:0] last_idx;
    logic            kill;

    assign last_idx = VA_W'(num_vecs_q - 1'b1);
    assign kill     = abort && (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        num_vecs_d  = num_vecs_q;
        wgt_rd_en_d = 1'b0;
        wgt_addr_d  = '0;
        act_rd_en_d = 1'b0;
        act_addr_d  = '0;
        load_w_d    = wgt_rd_en_q;
        act_valid_d = act_rd_en_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        res_idx_d   = res_valid ? res_idx_q + 1'b1 : res_idx_q;

        if (kill) begin
            state_d     = StIdle;
            load_w_d    = 1'b0;
            act_valid_d = 1'b0;
            res_idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        if (cfg_num_vecs == '0) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            num_vecs_d  = cfg_num_vecs;
                            state_d     = StLoadW;
                            wgt_rd_en_d = 1'b1;
                            wgt_addr_d  = WA_W'(ROWS - 1);
                        end
                    end
                end
                StLoadW: begin
                    // First activation read overlaps the final weight-load cycle.
                    if (wgt_addr_q == '0) begin
                        state_d     = StFeed;
                        act_rd_en_d = 1'b1;
                    end else begin
                        wgt_rd_en_d = 1'b1;
                        wgt_addr_d  = wgt_addr_q - 1'b1;
                    end
                end
                StFeed: begin
                    if (act_addr_q == last_idx) begin
                        state_d = StDrain;
                    end else begin
                        act_rd_en_d = 1'b1;
                        act_addr_d  = act_addr_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (res_valid && res_idx_q == last_idx) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        res_idx_d = '0;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            num_vecs_q  <= '0;
            wgt_rd_en_q <= 1'b0;
            wgt_addr_q  <= '0;
            load_w_q    <= 1'b0;
            act_rd_en_q <= 1'b0;
            act_addr_q  <= '0;
            act_valid_q <= 1'b0;
            res_idx_q   <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_vecs_q  <= num_vecs_d;
            wgt_rd_en_q <= wgt_rd_en_d;
            wgt_addr_q  <= wgt_addr_d;
            load_w_q    <= load_w_d;
            act_rd_en_q <= act_rd_en_d;
            act_addr_q  <= act_addr_d;
            act_valid_q <= act_valid_d;
            res_idx_q   <= res_idx_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    sa_valid_delay #(
        .DEPTH(RES_LAT)
    ) u_res_delay (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(kill),
        .valid_i(act_valid_q),
        .valid_o(res_valid)
    );

    assign busy            = (state_q != StIdle);
    assign done            = done_q;
    assign cfg_err         = cfg_err_q;
    assign wgt_rd_en       = wgt_rd_en_q;
    assign wgt_rd_addr     = wgt_addr_q;
    assign arr_load_weight = load_w_q;
    assign act_rd_en       = act_rd_en_q;
    assign act_rd_addr     = act_addr_q;
    assign arr_act_valid   = act_valid_q;
    assign res_idx         = res_idx_q;

endmodule
